exp3_unidade_gravacao: RTL
==========================

# exp3_unidade_gravacao

Write-side counterpart of the sequence-checking control unit: a Moore control unit plus datapath that programs the sequence memory. Starting from address 0, it waits for a `jogada` button press at each step, latches the switch value and issues a single-cycle write strobe. It then advances the address and stops after the last address, asserting `pronto`. It sits between the board switches/button and the synchronous-write sequence RAM that the checking unit later reads.

## Interface
- `ADDR_W`, 4: address/counter width
- `DATA_W`, 4: switch and memory word width
- `LAST_ADDR`, 2**ADDR_W-1: final address written; 0 ≤ `LAST_ADDR` ≤ 2**ADDR_W-1
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high
- `iniciar`  in  1  start request; sampled only in state `inicial`
- `jogada`  in  1  button level, already synchronized; one write per rising edge
- `chaves`  in  DATA_W  value to store
- `mem_we`  out  1  memory write enable, one-cycle pulse
- `mem_addr`  out  ADDR_W  write address (address counter value)
- `mem_dado`  out  DATA_W  write data (data register value)
- `pronto`  out  1  high for exactly one cycle, in state `fim`
- `db_estado`  out  4  state code for the 7-segment debug display
- `db_contagem`  out  ADDR_W  copy of `mem_addr` for debug

## Operation
States and their `db_estado` codes:
- `inicial` = 0
- `preparacao` = 1
- `espera` = 2
- `registra` = 4
- `grava` = 5
- `proximo` = 6
- `fim` = F
- any unused encoding displays E and returns to `inicial` on the next edge

Transitions:
- `inicial` → `preparacao` if `iniciar`, else stay.
- `preparacao` → `espera`.
- `espera` → `registra` if `jogada_pulso`, else stay.
- `registra` → `grava`.
- `grava` → `fim` if counter == `LAST_ADDR`, else `proximo`.
- `proximo` → `espera`.
- `fim` → `inicial`.

Moore outputs, decoded from the current state only:
- Counter clear: in `inicial` and `preparacao`.
- Counter increment: in `proximo`.
- Data register load from `chaves`: in `registra`.
- `mem_we`: in `grava`.
- `pronto`: in `fim`.

Datapath:
- Address counter is ADDR_W bits, synchronous clear and enable, with clear taking priority.
- It never wraps during a run, because `grava` exits to `fim` at `LAST_ADDR` before any increment.
- Data register is DATA_W bits and holds its value outside `registra`.
- `jogada_pulso` is an internal one-cycle pulse produced on each 0→1 transition of `jogada`.
- Pulses that arrive outside `espera` are discarded, not queued.
- Holding `jogada` high yields exactly one pulse and therefore exactly one write.

## Timing
- Reset (async): state `inicial`, counter 0, data register 0, edge-detector history 0. Output values:
  - `mem_we` = 0
  - `pronto` = 0
  - `mem_addr` = 0
  - `mem_dado` = 0
  - `db_estado` = 0
  - `db_contagem` = 0
- Reset asserted mid-run aborts immediately. No write strobe may appear while reset is high or on the edge it is released.
- Start latency: `iniciar` high at edge k puts the block in `preparacao` after k and in `espera` after k+1.
- Jogada latency: `jogada` rises before edge k, so `jogada_pulso` is high in cycle k→k+1. The block then enters:
  - `registra` after edge k+1, where `chaves` is sampled at edge k+2
  - `grava` after edge k+2, with `mem_we`=1 for one cycle
- During the `mem_we` cycle, `mem_addr` and `mem_dado` are stable. The memory captures the write at the edge that ends `grava`.
- Per-step minimum spacing: 4 cycles from `jogada_pulso` back to `espera`.
- Full run: `LAST_ADDR`+1 writes to addresses 0..`LAST_ADDR` in ascending order, then one `pronto` cycle, then `inicial`.
- Both `iniciar` and `jogada` high in `inicial`: only `iniciar` acts. The stale `jogada` edge is dropped, because the detector history is updated every cycle.

## Structure
- Shared package (`exp3_pkg`) holds:
  - the state encodings as 4-bit localparams (`inicial`…`fim`), which must stay identical to the checking unit's codes so one display decoder serves both
  - the debug error code E
- Sub-module `edge_detector`: clock, reset, `sinal` → `pulso`. It uses one flip-flop and `pulso` = `sinal` & ~`reg`, with reset value 0.
- Top-level contents: the FSM (state register, next-state logic, output decode), the address counter and the data register, all in this module.

## Test plan
- **Full programming run**, defaults: `iniciar`, then 16 `jogada` presses with `chaves` = 0..F. Required response:
  - exactly 16 one-cycle `mem_we` pulses with (`addr`,`dado`) = (i,i)
  - `pronto` high for one cycle after the 16th write
  - `db_estado` returns to 0
- **Held button**: `jogada` held high for 20 cycles in `espera`. Required: exactly one write, and the address then advances by 1.
- **Ignored inputs**: `jogada` pulsed in `inicial`, and `iniciar` pulsed during `espera`. Required: no `mem_we` and no state change other than the specified transitions.
- **Reset mid-run**: reset asserted while in `registra` at address 5. Required:
  - outputs immediately at their reset values, with no `mem_we`
  - a subsequent run restarts writing at address 0
- **Short sequence**, `LAST_ADDR`=3: four presses give writes to addresses 0..3, then `pronto`. `db_estado` must never show E.

Source files
------------

// File: rtl/exp3_pkg.sv
// Shared state codes for the sequence write and check control units.
// One 7-segment decoder serves both units, so these codes must stay in sync.
package exp3_pkg;

    localparam logic [3:0] inicial    = 4'h0;
    localparam logic [3:0] preparacao = 4'h1;
    localparam logic [3:0] espera     = 4'h2;
    localparam logic [3:0] registra   = 4'h4;
    localparam logic [3:0] grava      = 4'h5;
    localparam logic [3:0] proximo    = 4'h6;
    localparam logic [3:0] fim        = 4'hF;
    localparam logic [3:0] codigo_erro = 4'hE;

    typedef enum logic [3:0] {
        S_INICIAL    = inicial,
        S_PREPARACAO = preparacao,
        S_ESPERA     = espera,
        S_REGISTRA   = registra,
        S_GRAVA      = grava,
        S_PROXIMO    = proximo,
        S_FIM        = fim
    } estado_t;

endpackage

// File: rtl/exp3_unidade_gravacao_edge_detector.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of sinal.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sinal_reg <= 1'b0;
        else
            sinal_reg <= sinal;
    end

    assign pulso = sinal & ~sinal_reg;

endmodule

// File: rtl/exp3_unidade_gravacao.sv
// Sequence-memory programming unit: Moore FSM, address counter and data
// register that write one switch value per button press.
module exp3_unidade_gravacao
    import exp3_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int LAST_ADDR = 2**ADDR_W-1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic [DATA_W-1:0] chaves,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dado,
    output logic              pronto,
    output logic [3:0]        db_estado,
    output logic [ADDR_W-1:0] db_contagem
);

    localparam logic [ADDR_W-1:0] ultimo = ADDR_W'(LAST_ADDR);

    estado_t estado, proximo_estado;
    logic jogada_pulso;
    logic limpa, incrementa, carrega;
    logic [ADDR_W-1:0] contagem;
    logic [DATA_W-1:0] dado;

    edge_detector u_edge_detector (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (jogada_pulso)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= S_INICIAL;
        else
            estado <= proximo_estado;
    end

    // Pulses outside espera are simply ignored, never queued.
    always_comb begin
        proximo_estado = S_INICIAL;
        limpa          = 1'b0;
        incrementa     = 1'b0;
        carrega        = 1'b0;
        mem_we         = 1'b0;
        pronto         = 1'b0;
        db_estado      = codigo_erro;
        case (estado)
            S_INICIAL: begin
                proximo_estado = iniciar ? S_PREPARACAO : S_INICIAL;
                limpa          = 1'b1;
                db_estado      = inicial;
            end
            S_PREPARACAO: begin
                proximo_estado = S_ESPERA;
                limpa          = 1'b1;
                db_estado      = preparacao;
            end
            S_ESPERA: begin
                proximo_estado = jogada_pulso ? S_REGISTRA : S_ESPERA;
                db_estado      = espera;
            end
            S_REGISTRA: begin
                proximo_estado = S_GRAVA;
                carrega        = 1'b1;
                db_estado      = registra;
            end
            S_GRAVA: begin
                proximo_estado = (contagem == ultimo) ? S_FIM : S_PROXIMO;
                mem_we         = 1'b1;
                db_estado      = grava;
            end
            S_PROXIMO: begin
                proximo_estado = S_ESPERA;
                incrementa     = 1'b1;
                db_estado      = proximo;
            end
            S_FIM: begin
                proximo_estado = S_INICIAL;
                pronto         = 1'b1;
                db_estado      = fim;
            end
            default: begin
                proximo_estado = S_INICIAL;
                db_estado      = codigo_erro;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            contagem <= '0;
        else if (limpa)
            contagem <= '0;
        else if (incrementa)
            contagem <= contagem + ADDR_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            dado <= '0;
        else if (carrega)
            dado <= chaves;
    end

    assign mem_addr    = contagem;
    assign mem_dado    = dado;
    assign db_contagem = contagem;

endmodule
